// File: rtl/store_buffer.sv
// store_buffer -- posted-write FIFO between the core load/store path and a
// single-port data memory.
//
// Stores are accepted with a valid/ready handshake and drained into dmem on
// cycles where no load owns the port. A load whose word address matches any
// buffered store is stalled until the conflicting stores have drained.
//
// Build option: define SB_FORWARD_EN to let an aligned LW be satisfied
// directly from the youngest matching buffered SW. The port stays free to
// drain in the same cycle. Without it, every address hit stalls.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   st_valid/st_ready       store handshake; st_addr/st_data/st_funct3 payload
//   ld_req/ld_addr/ld_funct3 combinational load request
//   ld_rd                   load result (0 unless the load is served)
//   ld_stall                load must be held (address hit on a buffered store)
//   fence/fence_busy        fence_busy = fence && buffer not empty
//   count                   occupied entries
//   mem_we/mem_a/mem_wd/mem_funct3/mem_rd  dmem port
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [AW-1:0]                st_addr,
  input  logic [31:0]                  st_data,
  input  logic [2:0]                   st_funct3,
  input  logic                         ld_req,
  input  logic [AW-1:0]                ld_addr,
  input  logic [2:0]                   ld_funct3,
  output logic [31:0]                  ld_rd,
  output logic                         ld_stall,
  input  logic                         fence,
  output logic                         fence_busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         mem_we,
  output logic [AW-1:0]                mem_a,
  output logic [31:0]                  mem_wd,
  output logic [2:0]                   mem_funct3,
  input  logic [31:0]                  mem_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [2:0]    funct3;
  } sb_ent_t;

  sb_ent_t       ent_q [DEPTH];
  sb_ent_t       ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic    hit, fwd, ld_own, drain, push;
  sb_ent_t yng;
  sb_ent_t head_ent;

  assign head_ent = ent_q[head_q];

  // Scan occupied slots oldest to youngest; the last match is the youngest.
  // DEPTH is a power of two, so head+k wraps naturally in PW bits.
  always_comb begin
    logic [PW-1:0] slot;
    hit  = 1'b0;
    yng  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PW'(k);
      if (CW'(k) < cnt_q && ent_q[slot].addr[AW-1:2] == ld_addr[AW-1:2]) begin
        hit = 1'b1;
        yng = ent_q[slot];
      end
    end
    hit = hit && ld_req;
  end

`ifdef SB_FORWARD_EN
  assign fwd = hit && ld_funct3 == 3'b010 && ld_addr[1:0] == 2'b00 &&
               yng.funct3 == 3'b010;
`else
  assign fwd = 1'b0;
`endif

  // A hitting load never owns the port: either it stalls (drain takes the
  // port so the hazard clears) or it is forwarded (port is free to drain).
  assign ld_own     = rst_n && ld_req && !hit;
  assign drain      = !ld_own && cnt_q != '0;
  assign push       = st_valid && st_ready;
  assign ld_stall   = hit && !fwd;
  assign st_ready   = cnt_q != CW'(DEPTH);
  assign fence_busy = fence && cnt_q != '0;
  assign count      = cnt_q;

  always_comb begin
    mem_we     = 1'b0;
    mem_a      = ld_addr;
    mem_wd     = '0;
    mem_funct3 = 3'b010;
    ld_rd      = '0;
    if (ld_own) begin
      mem_funct3 = ld_funct3;
      ld_rd      = mem_rd;
    end else if (drain) begin
      mem_we     = 1'b1;
      mem_a      = head_ent.addr;
      mem_wd     = head_ent.data;
      mem_funct3 = head_ent.funct3;
    end
    if (fwd) ld_rd = yng.data;
  end

  always_comb begin
    ent_d  = ent_q;
    tail_d = tail_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    if (push) begin
      ent_d[tail_q] = '{addr: st_addr, data: st_data, funct3: st_funct3};
      tail_d        = tail_q + 1'b1;
    end
    if (drain) head_d = head_q + 1'b1;
    if (push && !drain)      cnt_d = cnt_q + 1'b1;
    else if (!push && drain) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry payload needs no reset: occupancy is defined by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_rd;
  logic        ld_stall;
  logic        fence;
  logic        fence_busy;
  logic [2:0]  count;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd;

  int n_chk = 0;
  int n_err = 0;
  logic mem_init;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_rd(ld_rd), .ld_stall(ld_stall),
    .fence(fence), .fence_busy(fence_busy), .count(count),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // dmem model: 1 KiB, word i preloaded with A5A5_0000 | i.
  logic [31:0] dmem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_we && mem_a < 32'h400) begin
      case (mem_funct3[1:0])
        2'b00:   dmem[mem_a[9:2]][{mem_a[1:0], 3'b000} +: 8]  <= mem_wd[7:0];
        2'b01:   dmem[mem_a[9:2]][{mem_a[1], 4'b0000} +: 16] <= mem_wd[15:0];
        default: dmem[mem_a[9:2]] <= mem_wd;
      endcase
    end
  end

  always_comb begin
    logic [31:0] w, sh;
    w  = (mem_a < 32'h400) ? dmem[mem_a[9:2]] : 32'h0;
    sh = w >> {mem_a[1:0], 3'b000};
    case (mem_funct3)
      3'b000:  mem_rd = {{24{sh[7]}}, sh[7:0]};
      3'b001:  mem_rd = {{16{sh[15]}}, sh[15:0]};
      3'b100:  mem_rd = {24'h0, sh[7:0]};
      3'b101:  mem_rd = {16'h0, sh[15:0]};
      default: mem_rd = w;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic st_push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    cyc();
    st_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = 3'b010;
    ld_req = 1'b1; ld_addr = 32'h200; ld_funct3 = 3'b010; fence = 1'b0;

    // Reset: outputs quiet even with a live load request
    repeat (3) cyc();
    mem_init = 1'b0;
    #1;
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_ld_stall", 32'(ld_stall), 0);
    chk("rst_fence_busy", 32'(fence_busy), 0);
    chk("rst_ld_rd", ld_rd, 0);
    rst_n = 1'b1; ld_req = 1'b0;
    cyc();

    // SW 0x40 = DEADBEEF, drained the next cycle
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hDEADBEEF; st_funct3 = 3'b010;
    #1;
    chk("t1_idle_we", 32'(mem_we), 0);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("t1_count1", 32'(count), 1);
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_a", mem_a, 32'h40);
    chk("t1_wd", mem_wd, 32'hDEADBEEF);
    cyc();
    #1;
    chk("t1_count0", 32'(count), 0);
    chk("t1_we_off", 32'(mem_we), 0);
    chk("t1_idle_f3", 32'(mem_funct3), 32'h2);
    chk("t1_idle_wd", mem_wd, 0);
    ld_req = 1'b1; ld_addr = 32'h40; ld_funct3 = 3'b010;
    #1;
    chk("t1_lw_stall", 32'(ld_stall), 0);
    chk("t1_lw_rd", ld_rd, 32'hDEADBEEF);
    cyc();

    // Fill while an unrelated load holds the port, then drain in order
    ld_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'h100 + 32'(4*i); st_data = 32'(i+1);
      #1;
      chk("t2_fill_we", 32'(mem_we), 0);
      cyc();
    end
    st_valid = 1'b0;
    #1;
    chk("t2_count4", 32'(count), 4);
    chk("t2_ready0", 32'(st_ready), 0);
    chk("t2_we0", 32'(mem_we), 0);
    chk("t2_ld_rd", ld_rd, 32'hA5A50080);
    ld_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_we", 32'(mem_we), 1);
      chk("t2_drain_a", mem_a, 32'h100 + 32'(4*i));
      chk("t2_drain_wd", mem_wd, 32'(i+1));
      cyc();
    end
    #1;
    chk("t2_count0", 32'(count), 0);

    // SB 0x41 then LBU 0x41: stall while the byte drains
    st_push(32'h41, 32'hFFFF_FFAA, 3'b000);
    ld_req = 1'b1; ld_addr = 32'h41; ld_funct3 = 3'b100;
    #1;
    chk("t3_stall", 32'(ld_stall), 1);
    chk("t3_we", 32'(mem_we), 1);
    chk("t3_a", mem_a, 32'h41);
    chk("t3_f3", 32'(mem_funct3), 0);
    chk("t3_rd_stalled", ld_rd, 0);
    cyc();
    #1;
    chk("t3_unstall", 32'(ld_stall), 0);
    chk("t3_lbu", ld_rd, 32'h0000_00AA);
    ld_addr = 32'h40; ld_funct3 = 3'b010;
    #1;
    chk("t3_lw_word", ld_rd, 32'hDEAD_AAEF);
    ld_req = 1'b0;
    cyc();

    // SW 0x80 then LW 0x80
    st_push(32'h80, 32'h1234_5678, 3'b010);
    ld_req = 1'b1; ld_addr = 32'h80; ld_funct3 = 3'b010;
    #1;
`ifdef SB_FORWARD_EN
    chk("t4_fwd_stall", 32'(ld_stall), 0);
    chk("t4_fwd_rd", ld_rd, 32'h1234_5678);
    chk("t4_fwd_drain", 32'(mem_we), 1);
`else
    chk("t4_stall", 32'(ld_stall), 1);
    chk("t4_rd_stalled", ld_rd, 0);
`endif
    cyc();
    #1;
    chk("t4_count0", 32'(count), 0);
    chk("t4_stall_done", 32'(ld_stall), 0);
    chk("t4_rd", ld_rd, 32'h1234_5678);
    ld_req = 1'b0;
    cyc();

    // Fence: three buffered stores, busy for three cycles
    ld_req = 1'b1; ld_addr = 32'h200;
    for (int i = 0; i < 3; i++) st_push(32'h180 + 32'(4*i), 32'h50 + 32'(i), 3'b010);
    ld_req = 1'b0; fence = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_busy", 32'(fence_busy), 1);
      cyc();
    end
    #1;
    chk("t5_idle", 32'(fence_busy), 0);
    chk("t5_count0", 32'(count), 0);
    fence = 1'b0;

    // Reset mid-drain: first store lands, second is discarded
    ld_req = 1'b1; ld_addr = 32'h200;
    st_push(32'h300, 32'h1111_1111, 3'b010);
    st_push(32'h304, 32'h2222_2222, 3'b010);
    ld_req = 1'b0;
    #1;
    chk("t6_drain_a", mem_a, 32'h300);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_we", 32'(mem_we), 0);
    cyc();
    #1;
    chk("t6_mem_first", dmem[8'hC0], 32'h1111_1111);
    chk("t6_mem_second", dmem[8'hC1], 32'hA5A5_00C1);
    rst_n = 1'b1;
    cyc();
    #1;
    chk("t6_post_count", 32'(count), 0);
    chk("t6_post_we", 32'(mem_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the core's load/store path and the single-port data memory (dmem).
- Accepts stores with a valid/ready handshake and drains them into dmem on cycles when no load owns the port.
- Multiplexes the dmem port (a, wd, we, funct3) between load and drain traffic.
- Detects load-after-store hazards and stalls the load until the conflicting stores have drained.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width; always equal to the data width of 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from the core.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  store data, unshifted (byte/half in low bits).
- st_funct3  in  3  000=SB, 001=SH, 010=SW; other codes stored as given.
- ld_req  in  1  load request this cycle (combinational load).
- ld_addr  in  32  load byte address.
- ld_funct3  in  3  load type (000/001/010/100/101).
- ld_rd  out  32  load result.
- ld_stall  out  1  load must be held; core freezes its PC.
- fence  in  1  core requests full drain.
- fence_busy  out  1  fence && buffer not empty.
- count  out  $clog2(DEPTH+1)  occupied entries.
- mem_we  out  1  dmem write enable.
- mem_a  out  32  dmem address.
- mem_wd  out  32  dmem write data.
- mem_funct3  out  3  dmem access type.
- mem_rd  in  32  dmem read data.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data, funct3}.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register.
- Reset (rst_n low, asynchronous):
  - Pointers and count go to 0; pending stores are discarded.
  - Outputs while in reset: mem_we=0, ld_stall=0, fence_busy=0, count=0, ld_rd=0, st_ready=1.
  - A reset that arrives mid-drain aborts the drain. No partial write is issued after reset is asserted.
- Enqueue:
  - st_ready = (count != DEPTH). There is no pass-through when full, even if a drain happens in the same cycle.
  - When st_valid && st_ready at a rising edge, write the entry at tail, then tail++.
- Hazard:
  - hit = ld_req && (any occupied entry with addr[31:2] == ld_addr[31:2]).
  - ld_stall = hit.
- Port ownership, evaluated combinationally each cycle:
  - Load owns the port when ld_req && !ld_stall.
    - mem_we=0, mem_a=ld_addr, mem_funct3=ld_funct3, ld_rd=mem_rd.
  - Otherwise, if count != 0, the port drains.
    - mem_we=1; mem_a, mem_wd, mem_funct3 come from the head entry.
    - head++ at the next rising edge.
  - Otherwise the port is idle.
    - mem_we=0, mem_a=ld_addr, mem_wd=0, mem_funct3=010.
  - ld_rd=0 whenever the load does not own the port.
- Latency: a store enqueued at edge N is written into dmem at the earliest at edge N+1, if the port is free in the cycle after N.
- Ordering: stores drain strictly in FIFO order, one per cycle.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
- Hazard resolution: drain has priority while ld_stall=1, so a stalled load always resolves within count cycles.
- Out-of-range addresses (>= 0x400): buffered and drained normally. dmem ignores the write, so no special handling is needed here.
- Fence: fence_busy=1 while fence && count!=0. fence does not block enqueue.

Optional Feature:
- Macro: SB_FORWARD_EN.
- When defined, forwarding applies if all of these hold:
  - ld_funct3=010,
  - ld_addr[1:0]=00,
  - the youngest matching entry has funct3=010.
- In that case:
  - ld_stall=0 and ld_rd = that entry's data;
  - the port is free to drain in the same cycle.
- Every other hit still stalls.
- When undefined, every hit stalls.

Test Plan:
- Reset, then SW 0x40 = 0xDEADBEEF with no loads. Required: mem_we=1 the cycle after enqueue, mem_a=0x40; count returns to 0; a later LW 0x40 gives ld_rd=0xDEADBEEF.
- Enqueue 4 stores (DEPTH=4) while ld_req is held with a non-matching address. Required: st_ready=0 with count=4; no writes occur; after ld_req drops, writes drain in order over 4 cycles.
- SB 0x41 = 0xAA, then LBU 0x41 immediately. Required: ld_stall=1 for at least 1 cycle; after the drain, ld_rd=0x000000AA.
- SW 0x80 = 0x12345678, then LW 0x80. Required: stalls without SB_FORWARD_EN; with it, ld_stall=0 and ld_rd=0x12345678 in the same cycle.
- Fill 3 entries, assert fence with no loads. Required: fence_busy=1 for 3 cycles, then 0.
- Fill 2 entries, pull rst_n low mid-drain. Required: count=0 and mem_we=0 immediately; dmem shows at most the first store.
